ascon_desc_seq: RTL and testbench
=================================

Name: ascon_desc_seq

Overview:
- Descriptor-driven sequencer that sits directly upstream of the ASCON OBI peripheral's subordinate port and feeds it.
- Walks a descriptor list in SRAM through one OBI manager port. Each descriptor causes either a register write to the ASCON peripheral or a poll of one of its registers.
- Lets software launch a full key/BDI/BDO/auth DMA setup and wait for completion without CPU involvement.
- All traffic uses a single OBI manager port; the system crossbar routes SRAM and peripheral addresses.

Parameters:
- AsconBase, 32'h2000_0000, byte base address of the ASCON peripheral register window.
- PollMax, 16'd1024, maximum poll reads per POLL descriptor before a timeout error.
- MaxDesc, 8'd64, maximum descriptors per run; reaching it without a LAST flag is an error.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  one-cycle pulse that launches a run; ignored while busy_o=1.
- desc_base_i  in  32  word-aligned byte address of descriptor 0, sampled on start_i.
- busy_o  out  1  high from the cycle after an accepted start until the cycle done_o pulses.
- done_o  out  1  one-cycle pulse at the end of a run, whether it succeeds or fails.
- err_o  out  1  sticky error flag; cleared by the next accepted start.
- err_code_o  out  2  0 none, 1 OBI err, 2 poll timeout, 3 MaxDesc overrun.
- desc_cnt_o  out  8  number of descriptors completed in the current or last run.
- obi_req_o  out  1  OBI request.
- obi_addr_o  out  32  OBI address.
- obi_we_o  out  1  OBI write enable.
- obi_be_o  out  4  OBI byte enables; always 4'hF.
- obi_wdata_o  out  32  OBI write data.
- obi_gnt_i  in  1  OBI grant.
- obi_rvalid_i  in  1  OBI response valid.
- obi_rdata_i  in  32  OBI read data.
- obi_err_i  in  1  OBI error; qualified by obi_rvalid_i.

Behaviour:
- Reset (async, rst_i=1):
  - State returns to IDLE.
  - All outputs are 0, including err_code_o and desc_cnt_o.
  - Poll counter and descriptor pointer are cleared.
  - An outstanding OBI transaction is abandoned; a late rvalid arriving in IDLE is ignored.
- Descriptor format: 2 words at ptr and ptr+4; the next descriptor is at ptr+8.
- W0 fields:
  - [31] LAST.
  - [30] OP: 0=WRITE, 1=POLL.
  - [9:0] register word index.
  - Other bits are ignored.
- W1 meaning:
  - WRITE: the data to write.
  - POLL: the mask; the poll completes when (rdata & mask)==mask.
- Target address: AsconBase + {idx,2'b00}, 32-bit addition with wrap.
- OBI rules:
  - At most one transaction is outstanding.
  - req and addr/we/wdata are held stable until the cycle gnt=1.
  - req drops in the cycle after grant.
  - The FSM waits for rvalid before issuing the next request; gnt and rvalid in the same cycle are legal.
- FSM states: IDLE, F0_REQ, F0_RSP, F1_REQ, F1_RSP, EX_REQ, EX_RSP, FINISH.
- IDLE:
  - start_i loads ptr=desc_base_i, clears desc_cnt, err and err_code, sets busy.
  - Next state is F0_REQ.
- F0 (fetch W0): read ptr; on rvalid latch W0, then go to F1.
- F1 (fetch W1): read ptr+4; on rvalid latch W1, then go to EX_REQ.
- EX WRITE: write W1 to the target address; on rvalid the descriptor completes.
- EX POLL:
  - Read the target address.
  - On rvalid, if the mask condition holds, the descriptor completes.
  - Otherwise increment the poll counter and reissue EX_REQ on the next cycle.
  - When the counter reaches PollMax without a match, set err_code=2 and go to FINISH.
- Descriptor completion:
  - desc_cnt increments (saturating at 255) and ptr advances by 8.
  - The poll counter clears.
  - If LAST, go to FINISH.
  - Else if desc_cnt==MaxDesc, set err_code=3 and go to FINISH.
  - Else go to F0_REQ.
- OBI error: obi_err_i with rvalid in any RSP state sets err_code=1 and goes to FINISH; a failed write is not counted.
- FINISH: done_o=1 for one cycle, busy_o drops in the same cycle, err_o=(err_code!=0); next state is IDLE.
- POLL with mask=0 completes on the first read response.
- start_i during busy is ignored without side effects.
- start_i in the FINISH cycle is ignored; a start is accepted only in IDLE.

Test Plan:
- Single WRITE: desc_base=0x1000 holds {LAST,WRITE,idx=4},0x40 -> one write of 0x40 to AsconBase+0x10; done_o pulses; desc_cnt_o=1; err_o=0.
- Three-descriptor chain:
  - Chain: WRITE idx4=16, WRITE idx11=0x1100, then LAST POLL idx6 mask=0x0200_0000.
  - Slave returns bit 25 clear 3 times, then set.
  - Required: 2 writes, 4 status reads, desc_cnt_o=3, err_o=0.
- Poll timeout: PollMax=8 and status never matches -> exactly 8 reads, err_code_o=2, done_o pulse, desc_cnt_o=0.
- OBI error: obi_err_i on the W1 fetch of descriptor 2 -> err_code_o=1, desc_cnt_o=1, no further requests issued.
- Backpressure: gnt held low for 5 cycles on each request -> addr/wdata stay stable while req=1, and the result matches the unstalled run.
- Async reset mid-run: assert rst_i during EX_RSP -> outputs go to 0 immediately; a late rvalid is ignored; a new start runs cleanly.

Source files
------------

// File: rtl/ascon_desc_seq.sv
// ascon_desc_seq -- descriptor-driven sequencer feeding the ASCON peripheral.
//
// Walks a list of two-word descriptors in SRAM over one OBI manager port.
// Each descriptor either writes a word into an ASCON register or polls an
// ASCON register until (rdata & mask) == mask. Software starts a run with a
// one-cycle start pulse and waits for the done pulse.
//
// Descriptor layout (byte address ptr):
//   W0 @ ptr   : [31] LAST, [30] OP (0 write, 1 poll), [9:0] register word index
//   W1 @ ptr+4 : write data (WRITE) or mask (POLL)
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   start_i, desc_base_i  run launch pulse and address of descriptor 0
//   busy_o, done_o        run in progress / one-cycle end-of-run pulse
//   err_o, err_code_o     sticky error and its cause (1 OBI, 2 poll timeout,
//                         3 descriptor limit reached without LAST)
//   desc_cnt_o            descriptors completed in the current or last run
//   obi_*                 OBI manager port, one transaction outstanding at most
module ascon_desc_seq #(
  parameter logic [31:0] AsconBase = 32'h2000_0000,
  parameter logic [15:0] PollMax   = 16'd1024,
  parameter logic [7:0]  MaxDesc   = 8'd64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] desc_base_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  output logic [7:0]  desc_cnt_o,
  output logic        obi_req_o,
  output logic [31:0] obi_addr_o,
  output logic        obi_we_o,
  output logic [3:0]  obi_be_o,
  output logic [31:0] obi_wdata_o,
  input  logic        obi_gnt_i,
  input  logic        obi_rvalid_i,
  input  logic [31:0] obi_rdata_i,
  input  logic        obi_err_i
);

  typedef enum logic [2:0] {
    IDLE, F0_REQ, F0_RSP, F1_REQ, F1_RSP, EX_REQ, EX_RSP, FINISH
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_OBI     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  state_e      state_q, state_d;
  logic [31:0] ptr_q, ptr_d;
  logic [7:0]  desc_cnt_q, desc_cnt_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic        last_q, last_d;
  logic        op_q, op_d;
  logic [9:0]  idx_q, idx_d;
  logic [31:0] w1_q, w1_d;

  logic        in_req, in_rsp, rsp_fire, poll_hit;
  logic [31:0] tgt_addr;
  logic [15:0] poll_cnt_inc;
  logic [7:0]  desc_cnt_inc;

  assign in_req = state_q inside {F0_REQ, F1_REQ, EX_REQ};
  assign in_rsp = state_q inside {F0_RSP, F1_RSP, EX_RSP};
  // A response is also taken when it arrives together with the grant, so a
  // zero-latency subordinate never leaves the FSM waiting in a RSP state.
  assign rsp_fire = obi_rvalid_i & (in_rsp | (in_req & obi_gnt_i));

  assign tgt_addr     = AsconBase + {20'd0, idx_q, 2'b00};
  assign poll_hit     = (obi_rdata_i & w1_q) == w1_q;
  assign poll_cnt_inc = poll_cnt_q + 16'd1;
  assign desc_cnt_inc = (desc_cnt_q == 8'hFF) ? 8'hFF : desc_cnt_q + 8'd1;

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    state_d    = state_q;
    ptr_d      = ptr_q;
    desc_cnt_d = desc_cnt_q;
    err_code_d = err_code_q;
    poll_cnt_d = poll_cnt_q;
    last_d     = last_q;
    op_d       = op_q;
    idx_d      = idx_q;
    w1_d       = w1_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          ptr_d      = desc_base_i;
          desc_cnt_d = 8'd0;
          err_code_d = ERR_NONE;
          poll_cnt_d = 16'd0;
          state_d    = F0_REQ;
        end
      end
      F0_REQ:  if (obi_gnt_i) state_d = F0_RSP;
      F1_REQ:  if (obi_gnt_i) state_d = F1_RSP;
      EX_REQ:  if (obi_gnt_i) state_d = EX_RSP;
      FINISH:  state_d = IDLE;
      default: ;
    endcase

    // Response handling overrides the request-phase transitions above.
    if (rsp_fire) begin
      if (obi_err_i) begin
        err_code_d = ERR_OBI;
        state_d    = FINISH;
      end else begin
        unique case (state_q)
          F0_REQ, F0_RSP: begin
            last_d  = obi_rdata_i[31];
            op_d    = obi_rdata_i[30];
            idx_d   = obi_rdata_i[9:0];
            state_d = F1_REQ;
          end
          F1_REQ, F1_RSP: begin
            w1_d    = obi_rdata_i;
            state_d = EX_REQ;
          end
          EX_REQ, EX_RSP: begin
            if (!op_q || poll_hit) begin
              desc_cnt_d = desc_cnt_inc;
              ptr_d      = ptr_q + 32'd8;
              poll_cnt_d = 16'd0;
              if (last_q) begin
                state_d = FINISH;
              end else if (desc_cnt_inc == MaxDesc) begin
                err_code_d = ERR_OVERRUN;
                state_d    = FINISH;
              end else begin
                state_d = F0_REQ;
              end
            end else if (poll_cnt_inc == PollMax) begin
              err_code_d = ERR_TIMEOUT;
              state_d    = FINISH;
            end else begin
              poll_cnt_d = poll_cnt_inc;
              state_d    = EX_REQ;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of process order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ptr_q      <= 32'd0;
      desc_cnt_q <= 8'd0;
      err_code_q <= ERR_NONE;
      poll_cnt_q <= 16'd0;
      last_q     <= 1'b0;
      op_q       <= 1'b0;
      idx_q      <= 10'd0;
      w1_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      desc_cnt_q <= desc_cnt_d;
      err_code_q <= err_code_d;
      poll_cnt_q <= poll_cnt_d;
      last_q     <= last_d;
      op_q       <= op_d;
      idx_q      <= idx_d;
      w1_q       <= w1_d;
    end
  end

  // Request outputs are pure functions of the registered state, so they hold
  // stable from the first request cycle until the grant.
  always_comb begin
    obi_addr_o = 32'd0;
    unique case (state_q)
      F0_REQ:  obi_addr_o = ptr_q;
      F1_REQ:  obi_addr_o = ptr_q + 32'd4;
      EX_REQ:  obi_addr_o = tgt_addr;
      default: ;
    endcase
  end

  assign obi_req_o   = in_req;
  assign obi_we_o    = (state_q == EX_REQ) & ~op_q;
  assign obi_be_o    = 4'hF;
  assign obi_wdata_o = obi_we_o ? w1_q : 32'd0;

  assign busy_o     = (state_q != IDLE) && (state_q != FINISH);
  assign done_o     = (state_q == FINISH);
  // err_code is cleared only by an accepted start, which makes err_o sticky.
  assign err_o      = (err_code_q != ERR_NONE);
  assign err_code_o = err_code_q;
  assign desc_cnt_o = desc_cnt_q;

endmodule

// File: tb/tb_ascon_desc_seq.sv
// tb_ascon_desc_seq -- bench for ascon_desc_seq.
//
// A descriptor-list model walks the SRAM image and the scripted poll data to
// predict every OBI transaction and the final count/error code of a run. A
// negedge process acts as the OBI subordinate (with programmable grant stall
// and response latency) and compares each granted request against the model.
module tb_ascon_desc_seq;

  localparam logic [31:0] ASCON_BASE = 32'h2000_0000;
  localparam int          POLL_MAX   = 8;
  localparam int          MAX_DESC   = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] desc_base_i = 32'd0;
  logic        busy_o, done_o, err_o;
  logic [1:0]  err_code_o;
  logic [7:0]  desc_cnt_o;
  logic        obi_req_o, obi_we_o;
  logic [31:0] obi_addr_o, obi_wdata_o;
  logic [3:0]  obi_be_o;
  logic        obi_gnt_i = 1'b0;
  logic        obi_rvalid_i = 1'b0;
  logic [31:0] obi_rdata_i = 32'd0;
  logic        obi_err_i = 1'b0;

  ascon_desc_seq #(
    .AsconBase(ASCON_BASE),
    .PollMax  (16'(POLL_MAX)),
    .MaxDesc  (8'(MAX_DESC))
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .desc_base_i (desc_base_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .err_code_o  (err_code_o),
    .desc_cnt_o  (desc_cnt_o),
    .obi_req_o   (obi_req_o),
    .obi_addr_o  (obi_addr_o),
    .obi_we_o    (obi_we_o),
    .obi_be_o    (obi_be_o),
    .obi_wdata_o (obi_wdata_o),
    .obi_gnt_i   (obi_gnt_i),
    .obi_rvalid_i(obi_rvalid_i),
    .obi_rdata_i (obi_rdata_i),
    .obi_err_i   (obi_err_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } txn_t;

  int          n_checks = 0;
  int          n_fail   = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] stat_q[$];
  logic [31:0] stat_default = 32'd0;
  txn_t        exp_q[$];
  bit          err_en = 1'b0;
  logic [31:0] err_addr = 32'd0;
  int          stall = 0;
  int          rsp_lat = 1;
  int          ex_grants = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'd0;
  endfunction

  function automatic bit is_err(input logic [31:0] a);
    return err_en && (a == err_addr);
  endfunction

  // Behavioural model: walk the list the way software describes it and list
  // every bus access in order, plus the final count and error code.
  task automatic model_run(input logic [31:0] base, output int cnt, output int code);
    logic [31:0] ptr, w0, w1, tgt, v;
    logic [31:0] sq[$];
    int polls;
    sq   = stat_q;
    ptr  = base;
    cnt  = 0;
    code = 0;
    exp_q.delete();
    forever begin
      exp_q.push_back('{ptr, 1'b0, 32'd0});
      if (is_err(ptr)) begin code = 1; return; end
      w0 = mem_rd(ptr);
      exp_q.push_back('{ptr + 32'd4, 1'b0, 32'd0});
      if (is_err(ptr + 32'd4)) begin code = 1; return; end
      w1  = mem_rd(ptr + 32'd4);
      tgt = ASCON_BASE + 32'(4 * int'(w0[9:0]));
      if (!w0[30]) begin
        exp_q.push_back('{tgt, 1'b1, w1});
        if (is_err(tgt)) begin code = 1; return; end
      end else begin
        polls = 0;
        forever begin
          exp_q.push_back('{tgt, 1'b0, 32'd0});
          if (is_err(tgt)) begin code = 1; return; end
          v = (sq.size() != 0) ? sq.pop_front() : stat_default;
          if ((v & w1) == w1) break;
          polls++;
          if (polls == POLL_MAX) begin code = 2; return; end
        end
      end
      cnt++;
      ptr = ptr + 32'd8;
      if (w0[31]) return;
      if (cnt == MAX_DESC) begin code = 3; return; end
    end
  endtask

  // OBI subordinate and scoreboard compare, evaluated mid-cycle.
  bit          pend = 1'b0;
  int          pend_wait = 0;
  logic [31:0] pend_data = 32'd0;
  bit          pend_err = 1'b0;
  int          wait_cnt = 0;
  bit          held = 1'b0;
  logic [31:0] h_addr = 32'd0, h_wdata = 32'd0;
  logic        h_we = 1'b0;

  always @(negedge clk_i) begin
    txn_t t;
    obi_rvalid_i = 1'b0;
    obi_err_i    = 1'b0;
    obi_rdata_i  = 32'd0;
    obi_gnt_i    = 1'b0;
    if (pend) begin
      if (pend_wait == 0) begin
        obi_rvalid_i = 1'b1;
        obi_rdata_i  = pend_data;
        obi_err_i    = pend_err;
        pend         = 1'b0;
      end else begin
        pend_wait--;
      end
    end
    if (obi_req_o && !rst_i) begin
      check("req only while busy", 32'(busy_o), 32'd1);
      check("byte enables", 32'(obi_be_o), 32'hF);
      if (held) begin
        check("addr stable while stalled", obi_addr_o, h_addr);
        check("we stable while stalled", 32'(obi_we_o), 32'(h_we));
        check("wdata stable while stalled", obi_wdata_o, h_wdata);
      end
      if (wait_cnt >= stall) begin
        obi_gnt_i = 1'b1;
        wait_cnt  = 0;
        held      = 1'b0;
        check("request was expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          t = exp_q.pop_front();
          check("txn addr", obi_addr_o, t.addr);
          check("txn we", 32'(obi_we_o), 32'(t.we));
          if (t.we) check("txn wdata", obi_wdata_o, t.wdata);
        end
        pend      = 1'b1;
        pend_wait = rsp_lat - 1;
        pend_err  = is_err(obi_addr_o);
        if (obi_addr_o >= ASCON_BASE) begin
          ex_grants++;
          pend_data = obi_we_o ? 32'd0
                    : ((stat_q.size() != 0) ? stat_q.pop_front() : stat_default);
        end else begin
          pend_data = mem_rd(obi_addr_o);
        end
      end else begin
        wait_cnt++;
        held    = 1'b1;
        h_addr  = obi_addr_o;
        h_we    = obi_we_o;
        h_wdata = obi_wdata_o;
      end
    end else begin
      wait_cnt = 0;
      held     = 1'b0;
    end
  end

  task automatic run(input string name, input logic [31:0] base, input int lit_n,
                     input int lit_cnt, input int lit_code, input int pin_idx,
                     input logic [31:0] pin_addr, input bit poke);
    int m_cnt, m_code, cyc;
    bit seen;
    model_run(base, m_cnt, m_code);
    // Hand-derived expectations pin the model itself.
    check({name, " model txn count"}, 32'(exp_q.size()), 32'(lit_n));
    check({name, " model desc count"}, 32'(m_cnt), 32'(lit_cnt));
    check({name, " model err code"}, 32'(m_code), 32'(lit_code));
    check({name, " model pinned addr"}, exp_q[pin_idx].addr, pin_addr);

    @(negedge clk_i);
    start_i = 1'b1;
    desc_base_i = base;
    @(negedge clk_i);
    start_i = 1'b0;
    desc_base_i = 32'd0;
    check({name, " busy after start"}, 32'(busy_o), 32'd1);
    check({name, " err cleared by start"}, 32'(err_o), 32'd0);
    check({name, " count cleared by start"}, 32'(desc_cnt_o), 32'd0);

    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 3000) begin
      start_i = poke && (cyc == 10);
      desc_base_i = start_i ? 32'h1500 : 32'd0;
      @(negedge clk_i);
      cyc++;
      if (done_o) seen = 1'b1;
    end
    start_i = 1'b0;
    check({name, " done within budget"}, 32'(seen), 32'd1);
    check({name, " busy low with done"}, 32'(busy_o), 32'd0);
    check({name, " desc_cnt"}, 32'(desc_cnt_o), 32'(m_cnt));
    check({name, " err_code"}, 32'(err_code_o), 32'(m_code));
    check({name, " err_o"}, 32'(err_o), 32'(m_code != 0));

    // A start in the done cycle must be ignored.
    start_i = 1'b1;
    desc_base_i = 32'h1000;
    @(negedge clk_i);
    start_i = 1'b0;
    desc_base_i = 32'd0;
    check({name, " done is one cycle"}, 32'(done_o), 32'd0);
    check({name, " start in done ignored"}, 32'(busy_o), 32'd0);
    repeat (3) @(negedge clk_i);
    check({name, " all txns issued"}, 32'(exp_q.size()), 32'd0);
    check({name, " count held after run"}, 32'(desc_cnt_o), 32'(m_cnt));
  endtask

  task automatic load_chain();
    mem[32'h1100] = 32'h0000_0004; mem[32'h1104] = 32'd16;
    mem[32'h1108] = 32'h0000_000B; mem[32'h110C] = 32'h0000_1100;
    mem[32'h1110] = 32'hC000_0006; mem[32'h1114] = 32'h0200_0000;
    stat_q = '{32'd0, 32'd0, 32'd0, 32'h0200_0000};
    stat_default = 32'd0;
  endtask

  initial begin
    int m_cnt, m_code, cyc;

    // Descriptor images.
    mem[32'h1000] = 32'h8000_0004; mem[32'h1004] = 32'h0000_0040;
    mem[32'h1200] = 32'hC000_0006; mem[32'h1204] = 32'h0000_0001;
    mem[32'h1300] = 32'h0000_0001; mem[32'h1304] = 32'h0000_00A5;
    mem[32'h1308] = 32'h8000_0002; mem[32'h130C] = 32'h0000_005A;
    for (int i = 0; i < 4; i++) begin
      mem[32'h1400 + 32'(8 * i)]     = 32'(i);
      mem[32'h1404 + 32'(8 * i)]     = 32'(i + 1);
    end
    mem[32'h1500] = 32'hC000_0006; mem[32'h1504] = 32'h0000_0000;

    repeat (2) @(negedge clk_i);
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset done", 32'(done_o), 32'd0);
    check("reset err", 32'(err_o), 32'd0);
    check("reset err_code", 32'(err_code_o), 32'd0);
    check("reset desc_cnt", 32'(desc_cnt_o), 32'd0);
    check("reset req", 32'(obi_req_o), 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    run("single write", 32'h1000, 3, 1, 0, 2, 32'h2000_0010, 1'b0);

    load_chain();
    run("chain", 32'h1100, 12, 3, 0, 5, 32'h2000_002C, 1'b1);

    stat_q.delete();
    stat_default = 32'h0000_0000;
    run("poll timeout", 32'h1200, 10, 0, 2, 2, 32'h2000_0018, 1'b0);

    err_en = 1'b1;
    err_addr = 32'h130C;
    run("obi error", 32'h1300, 5, 1, 1, 4, 32'h130C, 1'b0);
    err_en = 1'b0;

    load_chain();
    stall = 5;
    run("backpressure", 32'h1100, 12, 3, 0, 5, 32'h2000_002C, 1'b0);
    stall = 0;

    run("max desc", 32'h1400, 12, 4, 3, 11, 32'h2000_000C, 1'b0);

    stat_q.delete();
    stat_default = 32'h0000_0000;
    run("zero mask", 32'h1500, 3, 1, 0, 2, 32'h2000_0018, 1'b0);

    // Asynchronous reset while the second descriptor's write is outstanding.
    load_chain();
    rsp_lat = 3;
    ex_grants = 0;
    model_run(32'h1100, m_cnt, m_code);
    @(negedge clk_i);
    start_i = 1'b1;
    desc_base_i = 32'h1100;
    @(negedge clk_i);
    start_i = 1'b0;
    desc_base_i = 32'd0;
    cyc = 0;
    while (ex_grants < 2 && cyc < 500) begin
      @(negedge clk_i);
      #2;
      cyc++;
    end
    check("reset run reached 2nd write", 32'(ex_grants), 32'd2);
    @(posedge clk_i);
    #2;
    check("count before reset", 32'(desc_cnt_o), 32'd1);
    rst_i = 1'b1;
    exp_q.delete();
    #1;
    check("async reset busy", 32'(busy_o), 32'd0);
    check("async reset done", 32'(done_o), 32'd0);
    check("async reset err", 32'(err_o), 32'd0);
    check("async reset err_code", 32'(err_code_o), 32'd0);
    check("async reset desc_cnt", 32'(desc_cnt_o), 32'd0);
    check("async reset req", 32'(obi_req_o), 32'd0);
    check("async reset we", 32'(obi_we_o), 32'd0);
    check("async reset addr", obi_addr_o, 32'd0);
    check("async reset wdata", obi_wdata_o, 32'd0);
    @(negedge clk_i);
    #2;
    rst_i = 1'b0;
    // The abandoned write's response lands while the sequencer is idle.
    repeat (5) @(negedge clk_i);
    check("late rvalid busy", 32'(busy_o), 32'd0);
    check("late rvalid desc_cnt", 32'(desc_cnt_o), 32'd0);
    check("late rvalid err_code", 32'(err_code_o), 32'd0);
    check("late rvalid done", 32'(done_o), 32'd0);
    stat_q.delete();
    rsp_lat = 1;
    run("after reset", 32'h1000, 3, 1, 0, 2, 32'h2000_0010, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
